// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MULDIV_FAST_MULT_EN: single-cycle MULT/MULTU, divides stay iterative.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDctr,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic en);
        return en ? 32'(-v) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic en);
        return en ? 64'(-v) : v;
    endfunction

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div0;
    logic [31:0] a_raw;
    logic [31:0] mcand;
    logic [63:0] acc;

    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [63:0] prod_fix;

    assign op_signed = (MDctr == OP_MULT) || (MDctr == OP_DIV);
    assign a_mag     = op_signed ? mag32(A) : A;
    assign b_mag     = op_signed ? mag32(B) : B;

    // Multiply: acc = {partial product high, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {partial remainder, remaining dividend / quotient bits}
    assign div_trial = acc[63:31];
    assign div_diff  = div_trial - {1'b0, mcand};
    assign div_ge    = div_trial >= {1'b0, mcand};
    assign div_next  = div_ge ? {div_diff[31:0], acc[30:0], 1'b1}
                              : {div_trial[31:0], acc[30:0], 1'b0};

    assign prod_fix = cneg64(acc, neg_res);

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_prod = op_signed ? 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}))
                                 : 64'({32'd0, A} * {32'd0, B});
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (MDctr)
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
                                HI   <= fast_prod[63:32];
                                LO   <= fast_prod[31:0];
                                done <= 1'b1;
`else
                                acc     <= {32'd0, b_mag};
                                mcand   <= a_mag;
                                is_div  <= 1'b0;
                                neg_res <= op_signed & (A[31] ^ B[31]);
                                neg_rem <= 1'b0;
                                div0    <= 1'b0;
                                cnt     <= 5'd0;
                                busy    <= 1'b1;
                                state   <= CALC;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                acc     <= {32'd0, a_mag};
                                mcand   <= b_mag;
                                a_raw   <= A;
                                is_div  <= 1'b1;
                                neg_res <= op_signed & (A[31] ^ B[31]);
                                neg_rem <= op_signed & A[31];
                                div0    <= (B == 32'd0);
                                cnt     <= 5'd0;
                                busy    <= 1'b1;
                                state   <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        HI <= prod_fix[63:32];
                        LO <= prod_fix[31:0];
                    end else if (div0) begin
                        HI <= a_raw;
                        LO <= 32'hFFFF_FFFF;
                    end else begin
                        HI <= cneg32(acc[63:32], neg_rem);
                        LO <= cneg32(acc[31:0], neg_res);
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed ops with a HI/LO scoreboard.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  MDctr;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam int         DIV_BUSY = 33;

`ifdef MULDIV_FAST_MULT_EN
    localparam int          MUL_BUSY = 0;
    localparam logic [2:0]  RST_OP   = OP_DIVU;
    localparam logic [31:0] RST_A    = 32'd42;
    localparam logic [31:0] RST_B    = 32'd1;
`else
    localparam int          MUL_BUSY = 33;
    localparam logic [2:0]  RST_OP   = OP_MULTU;
    localparam logic [31:0] RST_A    = 32'd6;
    localparam logic [31:0] RST_B    = 32'd7;
`endif

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .MDctr (MDctr),
        .start (start),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          nbusy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drives a one-cycle request starting at the current negedge.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                          input int nbusy);
        exp_t e;
        MDctr = op;
        A     = a;
        B     = b;
        start = 1'b1;
        if (tag != "") begin
            e.tag = tag; e.hi = ehi; e.lo = elo; e.nbusy = nbusy;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        MDctr = 3'b000;
    endtask

    // Counts busy cycles until done, then compares against the scoreboard head.
    task automatic wait_done();
        exp_t e;
        int   nb   = 0;
        bit   seen = 1'b0;
        e = sb.pop_front();
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        chk({e.tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({e.tag, "_busy_cycles"}, 32'(nb), 32'(e.nbusy));
        chk({e.tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({e.tag, "_HI"}, HI, e.hi);
        chk({e.tag, "_LO"}, LO, e.lo);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                          input int nbusy);
        launch(op, a, b, tag, ehi, elo, nbusy);
        wait_done();
        @(negedge clk);
        chk({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0]        ra;
        logic [31:0]        rb;
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        bit                 dseen;

        rst = 1'b1; start = 1'b0; MDctr = 3'b000; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, "mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_BUSY);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_BUSY);
        run_op(OP_DIVU,  32'd100, 32'd0, "divu_by0", 32'h0000_0064, 32'hFFFF_FFFF, DIV_BUSY);
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0, "div_by0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_BUSY);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'h0000_0000, 32'h8000_0000, DIV_BUSY);
        run_op(OP_MULT,  32'h0001_0000, 32'h0001_0000, "mult_2p32", 32'h0000_0001, 32'h0000_0000, MUL_BUSY);
        run_op(OP_DIVU,  32'd9, 32'd2, "divu_9_2", 32'd1, 32'd4, DIV_BUSY);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd3;
            sp = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            run_op(OP_MULT, ra, rb, "rnd_mult", sp[63:32], sp[31:0], MUL_BUSY);
            up = {32'd0, ra} * {32'd0, rb};
            run_op(OP_MULTU, ra, rb, "rnd_multu", up[63:32], up[31:0], MUL_BUSY);
            sq = $signed(ra) / $signed(rb);
            sr = $signed(ra) % $signed(rb);
            run_op(OP_DIV, ra, rb, "rnd_div", sr, sq, DIV_BUSY);
            run_op(OP_DIVU, ra, rb, "rnd_divu", ra % rb, ra / rb, DIV_BUSY);
        end

        launch(OP_MTLO, 32'h1234_5678, 32'd0, "", 32'd0, 32'd0, 0);
        chk("mtlo_LO", LO, 32'h1234_5678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        chk("mtlo_done", 32'(done), 32'd0);
        launch(OP_MTHI, 32'hCAFE_F00D, 32'd0, "", 32'd0, 32'd0, 0);
        chk("mthi_HI", HI, 32'hCAFE_F00D);
        chk("mthi_busy", 32'(busy), 32'd0);

        // Requests during busy must be dropped, and HI/LO must hold through CALC.
        launch(OP_DIVU, 32'd10, 32'd3, "divu_ignore", 32'd1, 32'd3, DIV_BUSY - 2);
        MDctr = OP_MTHI; A = 32'd5; B = 32'd0; start = 1'b1;
        @(negedge clk);
        MDctr = OP_MULT; A = 32'd2; B = 32'd2;
        @(negedge clk);
        start = 1'b0; MDctr = 3'b000;
        chk("calc_HI_hold", HI, 32'hCAFE_F00D);
        chk("calc_LO_hold", LO, 32'h1234_5678);
        wait_done();
        @(negedge clk);
        chk("ignore_no_redo", 32'(busy), 32'd0);

        launch(OP_MULTU, 32'd3, 32'd5, "b2b_first", 32'd0, 32'd15, MUL_BUSY);
        wait_done();
        launch(OP_DIVU, 32'd15, 32'd4, "b2b_second", 32'd3, 32'd3, DIV_BUSY);
        wait_done();
        @(negedge clk);

        launch(RST_OP, RST_A, RST_B, "rst_abort", 32'd0, 32'd0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);
        dseen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) dseen = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(dseen), 32'd0);
        run_op(RST_OP, RST_A, RST_B, "after_rst", 32'd0, 32'd42,
               (RST_OP == OP_DIVU) ? DIV_BUSY : MUL_BUSY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
